// File: rtl/character_motion_if.sv
// rtl/character_motion_if.sv - request/position bundle between input logic, motion core and draw stage
interface character_motion_if;
  logic       tick;
  logic       move_right;
  logic       move_left;
  logic       jump;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       airborne;
  logic       update;

  modport master (
    output tick, move_right, move_left, jump,
    input  pos_x, pos_y, airborne, update
  );

  modport slave (
    input  tick, move_right, move_left, jump,
    output pos_x, pos_y, airborne, update
  );
endinterface

// File: rtl/character_motion.sv
// rtl/character_motion.sv - player position, horizontal clamp and jump/gravity with platform landing
module character_motion #(
  parameter logic [9:0] MAX_X       = 10'd320,
  parameter logic [9:0] CHAR_WIDTH  = 10'd8,
  parameter logic [9:0] FOOT_OFFSET = 10'd12,
  parameter logic [9:0] GROUND_Y    = 10'd205,
  parameter logic [9:0] JUMP_HEIGHT = 10'd40,
  parameter logic [9:0] START_X     = 10'd0,
  parameter logic [9:0] START_Y     = 10'd205
) (
  input  logic                clock,
  input  logic                resetn,
  character_motion_if.slave   bus
);

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } state_t;

  localparam int NUM_PLAT = 5;
  localparam logic [9:0] PLAT_Y  [NUM_PLAT] = '{10'd180, 10'd180, 10'd120, 10'd120, 10'd60};
  localparam logic [9:0] PLAT_X0 [NUM_PLAT] = '{10'd60,  10'd220, 10'd100, 10'd180, 10'd140};
  localparam logic [9:0] PLAT_X1 [NUM_PLAT] = '{10'd100, 10'd260, 10'd140, 10'd220, 10'd180};

  state_t     state;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] apex;
  logic       jump_q;
  logic       jump_pending;
  logic       airborne;
  logic       update;

  logic       supported;
  logic       jump_edge;
  logic       jump_req;
  logic [9:0] next_x;
  logic [9:0] foot_row;
  logic [9:0] right_col;

  // Support is judged on the pre-tick position so both axes move from the same snapshot.
  always_comb begin
    foot_row  = pos_y + FOOT_OFFSET;
    right_col = pos_x + CHAR_WIDTH - 10'd1;
    supported = (pos_y == GROUND_Y);
    for (int i = 0; i < NUM_PLAT; i++) begin
      if (foot_row == PLAT_Y[i] && right_col >= PLAT_X0[i] && pos_x <= PLAT_X1[i])
        supported = 1'b1;
    end
  end

  always_comb begin
    jump_edge = bus.jump & ~jump_q;
    jump_req  = jump_pending | jump_edge;
    next_x    = pos_x;
    if (bus.move_right && !bus.move_left) begin
      if (pos_x < MAX_X - CHAR_WIDTH)
        next_x = pos_x + 10'd1;
    end else if (bus.move_left && !bus.move_right) begin
      if (pos_x != 10'd0)
        next_x = pos_x - 10'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= GROUNDED;
      pos_x        <= START_X;
      pos_y        <= START_Y;
      apex         <= 10'd0;
      jump_q       <= 1'b0;
      jump_pending <= 1'b0;
      airborne     <= 1'b0;
      update       <= 1'b0;
    end else begin
      jump_q <= bus.jump;
      update <= bus.tick;
      if (bus.tick) begin
        // A press that is not used on this frame is dropped, never carried forward.
        jump_pending <= 1'b0;
        pos_x        <= next_x;
        case (state)
          GROUNDED: begin
            if (jump_req) begin
              apex     <= (pos_y >= JUMP_HEIGHT) ? pos_y - JUMP_HEIGHT : 10'd0;
              state    <= RISING;
              airborne <= 1'b1;
            end else if (!supported) begin
              state    <= FALLING;
              airborne <= 1'b1;
            end
          end
          RISING: begin
            if (pos_y == apex || pos_y == 10'd0) begin
              state    <= FALLING;
              airborne <= 1'b1;
            end else begin
              pos_y <= pos_y - 10'd1;
            end
          end
          FALLING: begin
            if (supported) begin
              state    <= GROUNDED;
              airborne <= 1'b0;
            end else if (pos_y < GROUND_Y) begin
              pos_y <= pos_y + 10'd1;
            end
          end
          default: begin
            state    <= GROUNDED;
            airborne <= 1'b0;
          end
        endcase
      end else if (jump_edge) begin
        jump_pending <= 1'b1;
      end
    end
  end

  assign bus.pos_x    = pos_x;
  assign bus.pos_y    = pos_y;
  assign bus.airborne = airborne;
  assign bus.update   = update;

endmodule

// File: tb/tb_character_motion.sv
// tb/tb_character_motion.sv - directed and random frames against a behavioural motion model
module tb_character_motion;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  character_motion_if bus();

  character_motion dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Reference world: position, mode (0 ground, 1 rising, 2 falling), apex, latched press.
  int m_x, m_y, m_mode, m_apex;
  bit m_pend, m_jq, m_upd;
  int upd_count;
  int plat_y  [5] = '{180, 180, 120, 120, 60};
  int plat_x0 [5] = '{60, 220, 100, 180, 140};
  int plat_x1 [5] = '{100, 260, 140, 220, 180};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_standing();
    if (m_y == 205) return 1'b1;
    foreach (plat_y[i])
      if (m_y + 12 == plat_y[i] && m_x + 7 >= plat_x0[i] && m_x <= plat_x1[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 205; m_mode = 0; m_apex = 0;
    m_pend = 0; m_jq = 0; m_upd = 0;
  endtask

  task automatic model_edge();
    bit edge_now, want, stand;
    int nx;
    edge_now = bus.jump && !m_jq;
    want = m_pend || edge_now;
    stand = m_standing();
    if (bus.tick) begin
      nx = m_x;
      if (bus.move_right && !bus.move_left) nx = (m_x + 1 > 312) ? 312 : m_x + 1;
      else if (bus.move_left && !bus.move_right) nx = (m_x == 0) ? 0 : m_x - 1;
      if (m_mode == 0) begin
        if (want) begin
          m_apex = (m_y >= 40) ? m_y - 40 : 0;
          m_mode = 1;
        end else if (!stand) m_mode = 2;
      end else if (m_mode == 1) begin
        if (m_y == m_apex || m_y == 0) m_mode = 2;
        else m_y = m_y - 1;
      end else begin
        if (stand) m_mode = 0;
        else m_y = m_y + 1;
      end
      m_x = nx;
      m_pend = 0;
    end else if (edge_now) begin
      m_pend = 1;
    end
    m_jq = bus.jump;
    m_upd = bus.tick;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    if (bus.update) upd_count++;
    check("pos_x", bus.pos_x, m_x);
    check("pos_y", bus.pos_y, m_y);
    check("airborne", bus.airborne, (m_mode != 0));
    check("update", bus.update, m_upd);
  endtask

  task automatic frame(input bit r, input bit l, input bit j);
    bus.move_right = r;
    bus.move_left = l;
    bus.jump = j;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask

  task automatic press_jump();
    bus.jump = 1'b1;
    step();
    bus.jump = 1'b0;
    step();
  endtask

  // Runs frames until the character is back on the ground; returns ticks used.
  task automatic until_landed(input bit r, input bit j, output int ticks);
    ticks = 0;
    do begin
      frame(r, 1'b0, j);
      ticks++;
    end while (bus.airborne && ticks < 300);
    if (ticks >= 300) check("landing_timeout", ticks, 0);
  endtask

  int n;
  int min_y;

  initial begin
    bus.tick = 0; bus.move_right = 0; bus.move_left = 0; bus.jump = 0;
    model_reset();
    upd_count = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", bus.pos_x, 0);
    check("rst_y", bus.pos_y, 205);
    check("rst_air", bus.airborne, 0);
    check("rst_upd", bus.update, 0);
    resetn = 1'b1;

    repeat (10) frame(0, 0, 0);
    check("idle_updates", upd_count, 10);
    check("idle_y", bus.pos_y, 205);

    repeat (5) frame(0, 1, 0);
    check("left_clamp", bus.pos_x, 0);
    repeat (320) frame(1, 0, 0);
    check("right_clamp", bus.pos_x, 312);
    repeat (3) frame(1, 1, 0);
    check("both_hold", bus.pos_x, 312);
    repeat (312) frame(0, 1, 0);
    check("back_home", bus.pos_x, 0);

    press_jump();
    n = 0; min_y = 205;
    do begin
      frame(0, 0, 0);
      n++;
      if (bus.pos_y < min_y) min_y = bus.pos_y;
    end while (bus.airborne && n < 300);
    check("jump_ticks", n, 83);
    check("jump_apex", min_y, 165);
    check("jump_land_y", bus.pos_y, 205);

    repeat (70) frame(1, 0, 0);
    check("walk_to_p1", bus.pos_x, 70);
    press_jump();
    until_landed(0, 0, n);
    check("p1_land_y", bus.pos_y, 168);
    repeat (31) frame(1, 0, 0);
    check("p1_edge_x", bus.pos_x, 101);
    check("p1_edge_still", bus.airborne, 0);
    frame(0, 0, 0);
    check("walk_off", bus.airborne, 1);
    until_landed(0, 0, n);
    check("walk_off_land", bus.pos_y, 205);

    bus.jump = 1'b1;
    step();
    until_landed(0, 1, n);
    repeat (10) frame(0, 0, 1);
    check("held_no_rejump", bus.airborne, 0);
    bus.jump = 1'b0;
    step();

    frame(0, 0, 1);
    frame(0, 0, 0);
    repeat (5) frame(0, 0, 0);
    press_jump();
    until_landed(0, 0, n);
    repeat (3) frame(0, 0, 0);
    check("air_press_dropped", bus.airborne, 0);

    press_jump();
    n = 0;
    do begin
      frame(0, 0, 0);
      n++;
    end while (bus.pos_y != 180 && n < 300);
    check("mid_rise_y", bus.pos_y, 180);
    #1 resetn = 1'b0;
    #1;
    check("async_x", bus.pos_x, 0);
    check("async_y", bus.pos_y, 205);
    check("async_air", bus.airborne, 0);
    check("async_upd", bus.update, 0);
    model_reset();
    @(posedge clock);
    #1 resetn = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      bus.tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.move_right = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) bus.move_left = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) bus.jump = $urandom_range(0, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/character_motion.md
Name: character_motion

Overview:
- Upstream of the pixel-scan draw stage: owns the player character's position and jump/gravity physics.
- Consumes a frame-rate tick from the rate limiter and active-high move/jump requests.
- Produces registered pos_x/pos_y (head-top-left reference, same convention the draw stage renders from), plus status flags.
- Replaces free-running position counters: no screen wrap-around, real landing on platforms and ground.

Parameters:
MAX_X, 10'd320, screen width in pixels
CHAR_WIDTH, 10'd8, character body width used for edge clamp and platform overlap
FOOT_OFFSET, 10'd12, pos_y + FOOT_OFFSET is the row directly under the feet
GROUND_Y, 10'd205, pos_y value when standing on the ground (floor limit)
JUMP_HEIGHT, 10'd40, pixels risen per jump
START_X, 10'd0, reset x position
START_Y, 10'd205, reset y position

Ports:
clock  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
tick  in  1  one-cycle frame-rate pulse from limiter; all motion happens only on cycles where tick=1
move_right  in  1  level, active-high request to move right
move_left  in  1  level, active-high request to move left
jump  in  1  level, active-high jump button (already inverted from KEY)
pos_x  out  10  character x position
pos_y  out  10  character y position
airborne  out  1  1 when state is RISING or FALLING
update  out  1  one-cycle pulse, high the cycle after a tick was processed

Behaviour:
- Reset (async, resetn=0): pos_x=START_X, pos_y=START_Y, state=GROUNDED, airborne=0, update=0, jump_pending=0, jump_q=0, apex=0.
- Platform table (fixed, surface row, x_start..x_end inclusive): P1 180, 60..100; P2 180, 220..260; P3 120, 100..140; P4 120, 180..220; P5 60, 140..180.
- supported = (pos_y == GROUND_Y) OR, for any platform: pos_y+FOOT_OFFSET == surface AND pos_x+CHAR_WIDTH-1 >= x_start AND pos_x <= x_end. Evaluated on pre-tick values.
- Jump capture: jump_q registers jump every cycle. A rising edge (jump & ~jump_q) sets jump_pending. At each tick jump_pending is cleared whether consumed or not, so there is no jump buffering across frames. An edge and a tick in the same cycle counts for that tick.
- Horizontal (every tick, all states, pre-tick values):
  - right&~left: pos_x+1, saturating at MAX_X-CHAR_WIDTH.
  - left&~right: pos_x-1, saturating at 0.
  - Both pressed or neither: hold.
- States, on tick only:
  - GROUNDED:
    - If jump requested (pending or edge this cycle): apex = (pos_y >= JUMP_HEIGHT) ? pos_y-JUMP_HEIGHT : 0; go to RISING; pos_y holds this tick.
    - Else if ~supported: go to FALLING (walked off an edge).
    - Else hold.
  - RISING:
    - If pos_y == apex or pos_y == 0: go to FALLING, pos_y holds.
    - Else pos_y-1.
    - No ceiling collision; platforms are pass-through from below.
  - FALLING:
    - If supported: go to GROUNDED, pos_y holds.
    - Else pos_y+1.
    - pos_y never exceeds GROUND_Y.
- Vertical and horizontal updates on the same tick both use pre-tick values.
- airborne is decoded from state, registered with it.
- update = registered tick.
- Between ticks all outputs are stable.
- All arithmetic is 10-bit unsigned; saturation rules above guarantee no wrap.
- Reset asserted mid-jump returns to the reset values immediately.

Test Plan:
- Reset with resetn=0 then release, no inputs, 10 ticks -> pos=(0,205), airborne=0, update pulses exactly once per tick.
- move_left held 5 ticks from x=0 -> pos_x stays 0. Then move_right held 320 ticks -> pos_x saturates at 312. Both keys held -> pos_x unchanged.
- Jump pulse at x=0, y=205 -> next tick RISING, pos_y reaches 165 after 40 more ticks, then FALLING, lands back at 205 (airborne=1 throughout, 0 on landing tick+1). Total airborne ticks = 1+40+1+40+1.
- Jump at x=70 from ground -> apex 165, falls 165->168, GROUNDED at pos_y=168 on P1. Then move_right to x=101 -> FALLING next tick, lands at 205.
- Jump held as a level across landing -> no second jump without a fresh rising edge. Jump edge while airborne -> ignored, pending cleared at next tick.
- resetn pulsed low mid-rise at pos_y=180 -> outputs immediately (0,205), state GROUNDED, airborne=0.
